// File: rtl/counter_event_log.sv
// counter_event_log
//   Turns edges on level event flags into timestamped records held in a
//   first-word-fall-through FIFO that a host drains with single-cycle pops.
//   Flags that arrive together are serialised lowest index first; the ones
//   that lose arbitration wait in a pending vector and are stamped with the
//   cycle in which they are actually written.
//
//   Optional build macro: COUNTER_EVENT_LOG_FALLING_EN
//     When defined, falling edges are logged as well (code bit3 = 1) and are
//     arbitrated after all rising edges.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   ev_in       in   [NUM_EVENTS] level event flags
//   pop         in   remove FIFO head (ignored when empty)
//   clear       in   synchronous flush of FIFO, pending and error state
//   rd_valid    out  FIFO not empty
//   rd_event    out  [4] head code: bit3 falling edge, bits2:0 input index
//   rd_ts       out  [TS_WIDTH] head timestamp
//   level       out  [clog2(DEPTH)+1] stored entry count
//   overflow    out  sticky, set when an event is dropped
//   drop_count  out  [8] dropped events, saturating at 255
module counter_event_log #(
   parameter int NUM_EVENTS = 3,
   parameter int DEPTH      = 16,
   parameter int TS_WIDTH   = 16
) (
   input  logic                       sys_clk,
   input  logic                       reset,
   input  logic [NUM_EVENTS-1:0]      ev_in,
   input  logic                       pop,
   input  logic                       clear,
   output logic                       rd_valid,
   output logic [3:0]                 rd_event,
   output logic [TS_WIDTH-1:0]        rd_ts,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [7:0]                 drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = 4 + TS_WIDTH;
`ifdef COUNTER_EVENT_LOG_FALLING_EN
   localparam int CW = 2 * NUM_EVENTS;
`else
   localparam int CW = NUM_EVENTS;
`endif

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [TS_WIDTH-1:0]   r_ts;
   logic [NUM_EVENTS-1:0] r_ev_q;
   logic [CW-1:0]         r_pend;
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;
   logic                  r_overflow;
   logic [7:0]            r_drop_cnt;
   logic [3:0]            r_head_ev;
   logic [TS_WIDTH-1:0]   r_head_ts;
   logic [EW-1:0]         r_mem [DEPTH];

   logic [NUM_EVENTS-1:0] w_rise;
   logic [CW-1:0]         w_edges;
   logic [CW-1:0]         w_cand;
   logic [CW-1:0]         w_sel_oh;
   logic [3:0]            w_sel_code;
   logic                  w_found;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_wr;
   logic                  w_drop;
   logic                  w_pass;
   logic [AW-1:0]         w_rd_ptr_n;
   logic [LW-1:0]         w_level_n;

   assign w_rise = ev_in & ~r_ev_q;
`ifdef COUNTER_EVENT_LOG_FALLING_EN
   // Rising edges occupy the low half so they always win over falling ones.
   assign w_edges = {(~ev_in & r_ev_q), w_rise};
`else
   assign w_edges = w_rise;
`endif
   assign w_cand = r_pend | w_edges;

   // Lowest set candidate wins.
   always_comb begin
      w_sel_oh   = '0;
      w_sel_code = '0;
      w_found    = 1'b0;
      for (int j = 0; j < CW; j++) begin
         if (w_cand[j] && !w_found) begin
            w_found     = 1'b1;
            w_sel_oh[j] = 1'b1;
            if (j < NUM_EVENTS) w_sel_code = {1'b0, 3'(j)};
            else                w_sel_code = {1'b1, 3'(j - NUM_EVENTS)};
         end
      end
   end

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_pop   = pop & ~w_empty & ~clear;
   // A full FIFO still accepts a write when the same cycle frees a slot.
   assign w_wr    = w_found & ~clear & (~w_full | w_pop);
   assign w_drop  = w_found & ~clear & w_full & ~w_pop;
   assign w_rd_ptr_n = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
   // The entry written this cycle becomes the head when nothing older remains.
   assign w_pass  = w_empty | ((r_level == LW'(1)) & w_pop);

   always_comb begin
      w_level_n = r_level;
      if (clear)              w_level_n = '0;
      else if (w_wr && !w_pop) w_level_n = r_level + LW'(1);
      else if (w_pop && !w_wr) w_level_n = r_level - LW'(1);
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_ts       <= '0;
         r_ev_q     <= '0;
         r_pend     <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
         r_head_ev  <= '0;
         r_head_ts  <= '0;
      end else begin
         r_ts   <= r_ts + TS_WIDTH'(1);
         r_ev_q <= ev_in;
         if (clear) begin
            r_pend     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
         end else begin
            // Selected candidate is consumed whether written or dropped.
            r_pend   <= w_cand & ~w_sel_oh;
            r_rd_ptr <= w_rd_ptr_n;
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_drop) begin
               r_overflow <= 1'b1;
               r_drop_cnt <= sat_inc8(r_drop_cnt);
            end
            // Head register holds its last value once the FIFO runs empty.
            if (w_level_n != '0) begin
               if (w_pass) begin
                  r_head_ev <= w_sel_code;
                  r_head_ts <= r_ts;
               end else begin
                  {r_head_ev, r_head_ts} <= r_mem[w_rd_ptr_n];
               end
            end
         end
         r_level <= w_level_n;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {w_sel_code, r_ts};
   end

   assign rd_valid   = ~w_empty;
   assign rd_event   = r_head_ev;
   assign rd_ts      = r_head_ts;
   assign level      = r_level;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_cnt;

endmodule

// File: doc/counter_event_log.md
Name: counter_event_log

Overview:
- Downstream stage of the two endpoint-controlled counters. Consumes their level flags (count1eq00, count1eq80, count2eqFF).
- Converts flag rising edges into timestamped event records held in a small FIFO.
- Presents the FIFO head for a host wire-out readout. The host pops entries with a trigger-in pulse, so short-lived flags are not missed between host polls.

Parameters:
- NUM_EVENTS, 3: number of event flag inputs; legal range 1..8.
- DEPTH, 16: FIFO entries; power of two, 2..256.
- TS_WIDTH, 16: width of the free-running timestamp counter.

Ports:
- sys_clk, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ev_in, input, NUM_EVENTS: level event flags, synchronous to sys_clk.
- pop, input, 1: one-cycle pulse; removes the FIFO head.
- clear, input, 1: synchronous flush.
- rd_valid, output, 1: FIFO not empty; head fields are meaningful.
- rd_event, output, 4: head event code; bit3 = falling edge, bits2:0 = input index.
- rd_ts, output, TS_WIDTH: head timestamp.
- level, output, clog2(DEPTH)+1: number of entries stored.
- overflow, output, 1: sticky; set when any event is dropped.
- drop_count, output, 8: number of dropped events, saturating.

Behaviour:
- Reset (asynchronous):
  - All outputs are 0: rd_valid, rd_event, rd_ts, level, overflow, drop_count.
  - Internal state is 0: ts counter, read/write pointers, pending vector, ev_q edge register.
  - A flag already high in the first cycle after reset release counts as a rising edge.
- Timestamp: ts increments by 1 every cycle and wraps from 2^TS_WIDTH-1 to 0. clear does not affect ts.
- Edge detect: ev_q <= ev_in every cycle. rise[i] = ev_in[i] & ~ev_q[i].
- Arbitration:
  - Candidates = pending | rise.
  - Each cycle with a non-zero candidate set, the lowest set index i is selected and written at that clock edge as {1'b0, i[2:0]} with the current-cycle ts.
  - All other candidates are stored into pending; the selected bit is cleared.
  - A deferred event keeps its original bit only. It is written later with the ts of the cycle in which it is actually written.
  - A new rise on an index already pending merges into that bit; no second entry and no drop.
- Latency: a rise in cycle N with the FIFO empty and nothing pending gives rd_valid=1 and that head in cycle N+1.
- Read (first-word fall-through):
  - rd_event and rd_ts always show the entry at the read pointer.
  - pop with rd_valid=1 advances the pointer; the next head (or rd_valid=0) appears in the following cycle.
  - pop with rd_valid=0 is ignored.
  - When empty, rd_event and rd_ts hold their last values.
- Full:
  - A write attempted with level==DEPTH and no simultaneous pop is dropped.
  - On a drop: overflow <= 1; drop_count increments, saturating at 255.
  - The dropped candidate is consumed, not kept pending.
- Full with simultaneous pop: pop and write both occur; level is unchanged; no drop.
- level: +1 on write only, -1 on pop only, unchanged on both or neither.
- clear:
  - Zeroes the pointers, level, pending, overflow and drop_count.
  - Sets rd_valid=0 in the next cycle.
  - Takes priority over pop and over writes in the same cycle; a same-cycle rise is discarded.
  - ev_q still updates, so a level that stays high is not re-logged.
- Reset asserted mid-operation: immediate return to reset state; no partial entries.

Optional Feature:
- Macro: COUNTER_EVENT_LOG_FALLING_EN.
- Defined:
  - Falling edges (~ev_in[i] & ev_q[i]) are also candidates, with code {1'b1, i[2:0]}.
  - Arbitration order: all rising candidates (ascending index) first, then falling (ascending index).
  - pending widens to 2*NUM_EVENTS.
- Undefined: falling edges are ignored; rd_event[3] is always 0; pending is NUM_EVENTS wide.

Test Plan:
- Reset, ev_in=0, run 10 cycles -> rd_valid=0, level=0, overflow=0, drop_count=0.
- ev_in[1] pulses high in one cycle (ts=0x0005), held high 20 cycles -> exactly one entry: rd_event=0x1, rd_ts=0x0005, rd_valid high the next cycle, level=1. Then pop -> rd_valid=0 the following cycle.
- ev_in goes 000->111 in a cycle with ts=0x0040 -> three entries, in order: (0x0, 0x0040), (0x1, 0x0041), (0x2, 0x0042); level=3 after three cycles.
- Fill to DEPTH=16, then 3 more rises with no pop -> level=16, overflow=1, drop_count=3. Next, a rise in the same cycle as a pop -> level stays 16, drop_count stays 3.
- level=5 and overflow=1; assert clear together with pop and a rise -> next cycle level=0, rd_valid=0, overflow=0, drop_count=0, no entry logged.
- With COUNTER_EVENT_LOG_FALLING_EN: ev_in[2] rises at ts=0x0100 and falls at ts=0x0108 -> entries (0x2, 0x0100) then (0xA, 0x0108). Without the macro, only (0x2, 0x0100).
